// File: rtl/lfsr_pkg.sv
// Definitions shared by the LFSR generator and checker: FSM states, width limits
// and the Fibonacci tap table.
package lfsr_pkg;

    typedef enum logic {
        SYNC  = 1'b0,
        CHECK = 1'b1
    } lfsr_state_e;

    localparam int LFSR_MIN_N = 2;
    localparam int LFSR_MAX_N = 8;

    // Bit k of the mask selects state bit s[k] into the feedback XOR.
    function automatic logic [7:0] lfsr_taps(int n);
        case (n)
            2:       return 8'h03;
            3:       return 8'h06;
            4:       return 8'h0C;
            5:       return 8'h14;
            6:       return 8'h30;
            7:       return 8'h60;
            8:       return 8'hB8;
            default: return 8'h00;
        endcase
    endfunction

endpackage

// File: rtl/lfsr_checker_if.sv
// Stream and status bundle between a stream source and the LFSR checker.
interface lfsr_checker_if #(
    parameter int CNT_W = 16
);
    logic             din;
    logic             din_valid;
    logic             clear_err;
    logic             locked;
    logic             bit_err;
    logic [CNT_W-1:0] err_count;
    logic             period_ok;

    modport master (
        output din, din_valid, clear_err,
        input  locked, bit_err, err_count, period_ok
    );

    modport slave (
        input  din, din_valid, clear_err,
        output locked, bit_err, err_count, period_ok
    );
endinterface

// File: rtl/lfsr_feedback.sv
// Combinational Fibonacci feedback bit; both link ends instantiate this so the
// polynomial can never drift between generator and checker.
module lfsr_feedback
    import lfsr_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0] state,
    output logic         fb
);
    localparam logic [7:0] TAPS = lfsr_taps(N);

    assign fb = ^(state & TAPS[N-1:0]);
endmodule

// File: rtl/lfsr_checker.sv
// Self-synchronising PRBS checker: loads N received bits as its state, then
// flywheels the LFSR and compares each received bit against the prediction.
module lfsr_checker
    import lfsr_pkg::*;
#(
    parameter int N         = 4,
    parameter int ERR_LIMIT = 4,
    parameter int CNT_W     = 16
) (
    input  logic           clk,
    input  logic           reset,
    lfsr_checker_if.slave  bus
);
    localparam int FILL_W = $clog2(N + 1);
    localparam int CONS_W = $clog2(ERR_LIMIT + 1);
    localparam int PERIOD = (1 << N) - 1;

    if (N < LFSR_MIN_N || N > LFSR_MAX_N) begin : g_bad_n
        $error("lfsr_checker: N=%0d outside %0d..%0d", N, LFSR_MIN_N, LFSR_MAX_N);
    end
    if (ERR_LIMIT < 1) begin : g_bad_limit
        $error("lfsr_checker: ERR_LIMIT must be >= 1");
    end

    lfsr_state_e       state_q, state_d;
    logic [N-1:0]      reg_q, reg_d;
    logic [FILL_W-1:0] fill_q, fill_d;
    logic [CONS_W-1:0] consec_q, consec_d;
    logic [N-1:0]      per_q, per_d;
    logic              clean_q, clean_d;
    logic [CNT_W-1:0]  err_q, err_d;
    logic              locked_q, bit_err_q, pok_q;
    logic              pred, mism, pok_d;

    lfsr_feedback #(.N(N)) u_fb (
        .state (reg_q),
        .fb    (pred)
    );

    always_comb begin
        state_d  = state_q;
        reg_d    = reg_q;
        fill_d   = fill_q;
        consec_d = consec_q;
        per_d    = per_q;
        clean_d  = clean_q;
        err_d    = err_q;
        mism     = 1'b0;
        pok_d    = 1'b0;
        if (bus.din_valid) begin
            case (state_q)
                SYNC: begin
                    reg_d = {reg_q[N-2:0], bus.din};
                    if (fill_q == FILL_W'(N - 1)) begin
                        fill_d = '0;
                        // An all-zero fill is the LFSR lock-up state; refill instead.
                        if (|reg_d) begin
                            state_d  = CHECK;
                            clean_d  = 1'b1;
                            per_d    = '0;
                            consec_d = '0;
                        end
                    end else begin
                        fill_d = fill_q + 1'b1;
                    end
                end
                CHECK: begin
                    // Flywheel on the prediction so line errors never enter the state.
                    reg_d = {reg_q[N-2:0], pred};
                    mism  = bus.din ^ pred;
                    if (mism) begin
                        consec_d = consec_q + 1'b1;
                        clean_d  = 1'b0;
                    end else begin
                        consec_d = '0;
                    end
                    if (mism && consec_q == CONS_W'(ERR_LIMIT - 1)) begin
                        state_d  = SYNC;
                        fill_d   = '0;
                        per_d    = '0;
                        consec_d = '0;
                    end else if (per_q == N'(PERIOD - 1)) begin
                        per_d   = '0;
                        pok_d   = clean_q & ~mism;
                        clean_d = 1'b1;
                    end else begin
                        per_d = per_q + 1'b1;
                    end
                end
                default: state_d = SYNC;
            endcase
        end
        if (bus.clear_err)
            err_d = '0;
        else if (mism && !(&err_q))
            err_d = err_q + 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= SYNC;
            reg_q     <= '0;
            fill_q    <= '0;
            consec_q  <= '0;
            per_q     <= '0;
            clean_q   <= 1'b0;
            err_q     <= '0;
            locked_q  <= 1'b0;
            bit_err_q <= 1'b0;
            pok_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            reg_q     <= reg_d;
            fill_q    <= fill_d;
            consec_q  <= consec_d;
            per_q     <= per_d;
            clean_q   <= clean_d;
            err_q     <= err_d;
            locked_q  <= (state_d == CHECK);
            bit_err_q <= mism;
            pok_q     <= pok_d;
        end
    end

    assign bus.locked    = locked_q;
    assign bus.bit_err   = bit_err_q;
    assign bus.err_count = err_q;
    assign bus.period_ok = pok_q;
endmodule

// File: doc/lfsr_checker.md
Name: lfsr_checker

Overview:
- Receive-side partner of the LFSR generator.
- Takes the generator's serial output stream and self-synchronises by loading N received bits as its state.
- Then predicts each following bit with the same Fibonacci polynomial, flags mismatches, counts errors, and reports clean full periods.
- Sits at the far end of a link or loopback, and is used for BIST and link-quality checks.

Parameters:
- N, 4, LFSR width; legal range 2..8; any other value is an elaboration-time $error.
- ERR_LIMIT, 4, consecutive mismatches that cause loss of lock (>=1).
- CNT_W, 16, width of the error counter.

Ports:
- clk  input  1  single clock; all logic on rising edge.
- reset  input  1  asynchronous, active-high; clears all state and outputs immediately.
- din  input  1  received stream bit.
- din_valid  input  1  din is sampled only when high; low cycles stall all state.
- clear_err  input  1  synchronous clear of err_count.
- locked  output  1  checker is synchronised and comparing bits.
- bit_err  output  1  one-cycle pulse: the sampled bit mismatched its prediction.
- err_count  output  CNT_W  saturating total mismatch count.
- period_ok  output  1  one-cycle pulse: 2^N-1 consecutive checked bits had no mismatch.

Behaviour:
- Stream convention: each generator step is s' = {s[N-2:0], f(s)}, and the transmitted bit is f(s).
- Taps f:
  - N=2: s1^s0
  - N=3: s2^s1
  - N=4: s3^s2
  - N=5: s4^s2
  - N=6: s5^s4
  - N=7: s6^s5
  - N=8: s7^s5^s4^s3
- Reset values: every output is 0, the FSM is in SYNC, and all internal registers and counters are 0.
- FSM state SYNC:
  - Each valid bit shifts into reg, i.e. reg <= {reg[N-2:0], din}, and fill_cnt increments.
  - After the N-th valid bit:
    - If the resulting reg is non-zero, go to CHECK; locked rises the following cycle.
    - If reg is all-zero (lock-up state), stay in SYNC with fill_cnt = 0 and refill.
- FSM state CHECK:
  - On each valid bit, compute p = f(reg) and compare din with p.
  - reg <= {reg[N-2:0], p}. This is a flywheel: received errors never corrupt the state.
  - On mismatch:
    - bit_err pulses the next cycle (1-cycle registered latency).
    - err_count increments, saturating at all-ones.
    - consec_cnt increments.
    - The period-clean flag clears.
  - On match, consec_cnt clears.
  - When consec_cnt reaches ERR_LIMIT: go to SYNC, locked falls the next cycle, fill_cnt and period counter are reset, and refill starts with the next valid bit. The error that triggers this is still counted and pulsed.
- Period tracking:
  - In CHECK, per_cnt counts checked bits.
  - When it reaches 2^N-1, it wraps to 0.
  - period_ok pulses the next cycle if the clean flag is still set.
  - The clean flag then re-arms.
- Registered outputs: locked, bit_err, period_ok and err_count are all registered.
- Stall: with din_valid = 0, nothing changes and pulses deassert.
- clear_err:
  - err_count goes to 0 the next cycle.
  - If a mismatch occurs in the same cycle, clear wins (count = 0) but bit_err still pulses.
  - clear_err does not affect lock.
- Reset mid-operation: asynchronous. locked, bit_err and period_ok drop immediately, and the FSM goes to SYNC.

Decomposition:
- Shared package lfsr_pkg, also used by the generator. It contains:
  - state enum {SYNC, CHECK};
  - function lfsr_taps(int n) returning an 8-bit tap mask;
  - constants LFSR_MIN_N = 2 and LFSR_MAX_N = 8.
- Sub-module lfsr_feedback: combinational, parameter N, input state[N-1:0], output fb = ^(state & taps). Shared with the generator so both ends use the same polynomial.

Test Plan:
- Reset and idle:
  - Stimulus: assert reset mid-stream, or hold din_valid = 0.
  - Response: all outputs 0; no state change while idle.
- Clean stream (N=4, generator seed 0001):
  - Stimulus: stream 001101011110001, repeated.
  - Response: locked high the cycle after the 4th valid bit (reg = 0011); no bit_err; period_ok pulses after the 19th valid bit and every 15 bits thereafter.
- Single bit error:
  - Stimulus: invert the 7th bit of the clean stream.
  - Response: one bit_err pulse; err_count = 1; locked stays 1; next bits are error-free; that period's period_ok is suppressed and the following one is present.
- All-zero stream:
  - Stimulus: 12 zero bits.
  - Response: locked never asserts; err_count = 0.
- Loss of lock (ERR_LIMIT = 4):
  - Stimulus: invert 4 consecutive bits after lock.
  - Response: 4 bit_err pulses; err_count = 4; locked falls; relock after 4 further correct bits.
- clear_err and saturation (CNT_W = 2):
  - Stimulus: clear_err coincident with a mismatch.
  - Response: err_count = 0 and bit_err = 1.
  - Stimulus: force 5 isolated errors.
  - Response: err_count saturates at 3.
